// File: rtl/fetch_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_arbiter_pkg
// Description : Shared CPU definitions for the instruction-fetch arbiter and
//               its round-robin picker: machine word constants, default
//               address/data widths, arbiter state encoding and a helper
//               for index-width calculation.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_arbiter_pkg;

  localparam int BYTESIZE   = 8;
  localparam int WORDSIZE   = 4;                    // bytes per word
  localparam int BITNESS    = BYTESIZE * WORDSIZE;  // machine word in bits

  localparam int DEF_ADDR_W = BITNESS;
  localparam int DEF_DATA_W = BITNESS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } fetch_state_e;

  // Width of an index into n requesters; a single requester still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : fetch_arbiter_rr_pick
// Description : Combinational round-robin priority encoder. Returns the
//               first set request bit searching upward from ptr and wrapping
//               modulo N. Reusable by any N-way round-robin arbiter.
// Ports       : req   - request vector (N bits)
//               ptr   - highest-priority index this cycle (must be < N)
//               valid - at least one request is set
//               index - winning request index (0 when valid is low)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_arbiter_rr_pick
  import fetch_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] index
);

  // Walk offsets from farthest to nearest so the nearest set bit to ptr
  // is the last (and therefore winning) assignment.
  always_comb begin
    int j;
    logic [PTR_W-1:0] w_idx;
    j     = 0;
    w_idx = '0;
    valid = |req;
    index = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      w_idx = PTR_W'(j);
      if (req[w_idx]) index = w_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fetch_arbiter
// Description : Round-robin arbiter sharing one instruction-memory read port
//               between NUM_CORES fetch units. One transaction at a time:
//               pick (IDLE) -> req/gnt handshake (ISSUE) -> wait for read
//               data or timeout (WAIT) -> return data and rotate priority.
// Ports       : clock, reset_n            - clock / async active-low reset
//               req, addr                 - per-core fetch requests/addresses
//               ack                       - one-hot, memory accepted request
//               rvalid, rdata, err        - one-hot data return, shared data,
//                                           timeout flag
//               owner, busy               - core being served, in progress
//               mem_req, mem_addr, mem_gnt- memory request handshake
//               mem_rvalid, mem_rdata     - memory read response
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_arbiter
  import fetch_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TIMEOUT   = 255
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr,
  output logic [NUM_CORES-1:0]          ack,
  output logic [NUM_CORES-1:0]          rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic                          err,
  output logic [2:0]                    owner,
  output logic                          busy,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_gnt,
  input  logic                          mem_rvalid,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int c_ptr_w = ptr_width(NUM_CORES);
  localparam int c_cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The counter starts at 0 in the first WAIT cycle, so the last allowed
  // WAIT cycle is TIMEOUT-1: memory gets exactly TIMEOUT cycles to answer.
  localparam logic [c_cnt_w-1:0] c_cnt_last =
    (TIMEOUT > 0) ? c_cnt_w'(TIMEOUT - 1) : '0;

  fetch_state_e           r_state;
  fetch_state_e           w_state_next;

  logic [c_ptr_w-1:0]     r_rr_ptr;
  logic [c_ptr_w-1:0]     r_owner;
  logic [ADDR_W-1:0]      r_addr;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [DATA_W-1:0]      r_rdata;
  logic [NUM_CORES-1:0]   r_rvalid;
  logic                   r_err;
  logic                   r_busy;

  logic                   w_pick_valid;
  logic [c_ptr_w-1:0]     w_pick_idx;
  logic [ADDR_W-1:0]      w_pick_addr;
  logic [NUM_CORES-1:0]   w_owner_oh;
  logic [c_ptr_w-1:0]     w_ptr_next;
  logic                   w_accept;
  logic                   w_grant;
  logic                   w_resp;
  logic                   w_timeout;
  logic                   w_done;

  fetch_arbiter_rr_pick #(
    .N     (NUM_CORES),
    .PTR_W (c_ptr_w)
  ) u_rr_pick (
    .req   (req),
    .ptr   (r_rr_ptr),
    .valid (w_pick_valid),
    .index (w_pick_idx)
  );

  // Address mux with constant slices keeps the select width-clean.
  always_comb begin
    w_pick_addr = '0;
    w_owner_oh  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_pick_idx == c_ptr_w'(i)) w_pick_addr = addr[i*ADDR_W +: ADDR_W];
      w_owner_oh[i] = (r_owner == c_ptr_w'(i));
    end
  end

  assign w_ptr_next = (r_owner == c_ptr_w'(NUM_CORES - 1)) ? '0 : r_owner + 1'b1;
  assign w_done     = w_resp | w_timeout;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // --------------------------------------------------------------------------
  // Next state and handshake outputs. ack is combinational from mem_gnt so
  // it lines up with the accepting cycle. mem_rvalid is only looked at in
  // WAIT, which drops late, spurious and gnt-coincident responses.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_grant      = 1'b0;
    w_resp       = 1'b0;
    w_timeout    = 1'b0;
    mem_req      = 1'b0;
    ack          = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          w_grant      = 1'b1;
          ack          = w_owner_oh;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          w_resp       = 1'b1;
          w_state_next = ST_IDLE;
        end else if ((TIMEOUT > 0) && (r_cnt == c_cnt_last)) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_rvalid <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_rvalid <= '0;
      r_err    <= 1'b0;

      if (w_accept) begin
        r_owner <= w_pick_idx;
        r_addr  <= w_pick_addr;
        r_busy  <= 1'b1;
      end

      // Counter is unused when the timeout is disabled, so leave it idle.
      if (w_grant) begin
        r_cnt <= '0;
      end else if ((r_state == ST_WAIT) && (TIMEOUT > 0)) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_done) begin
        r_rvalid <= w_owner_oh;
        r_err    <= w_timeout;
        r_rdata  <= w_resp ? mem_rdata : '0;
        r_busy   <= 1'b0;
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

  assign rvalid   = r_rvalid;
  assign rdata    = r_rdata;
  assign err      = r_err;
  assign owner    = 3'(r_owner);
  assign busy     = r_busy;
  assign mem_addr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_arbiter
// Description : Self-checking bench for fetch_arbiter. Directed stimulus
//               pushes expected ack/response records into queues; a monitor
//               pops and compares whenever the DUT pulses ack or rvalid.
//               A second instance with the timeout disabled shares all
//               inputs and is checked directly in the timeout scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_arbiter;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NC-1:0]     req = '0;
  logic [NC*AW-1:0]  addr = '0;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [DW-1:0]     mem_rdata = '0;

  logic [NC-1:0]     ack, rvalid;
  logic [DW-1:0]     rdata;
  logic              err, busy, mem_req;
  logic [2:0]        owner;
  logic [AW-1:0]     mem_addr;

  logic [NC-1:0]     nt_ack, nt_rvalid;
  logic [DW-1:0]     nt_rdata;
  logic              nt_err, nt_busy, nt_mem_req;
  logic [2:0]        nt_owner;
  logic [AW-1:0]     nt_mem_addr;

  fetch_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) u_dut (
    .clock(clock), .reset_n(reset_n), .req(req), .addr(addr),
    .ack(ack), .rvalid(rvalid), .rdata(rdata), .err(err), .owner(owner),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  fetch_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(0)) u_dut_nt (
    .clock(clock), .reset_n(reset_n), .req(req), .addr(addr),
    .ack(nt_ack), .rvalid(nt_rvalid), .rdata(nt_rdata), .err(nt_err),
    .owner(nt_owner), .busy(nt_busy), .mem_req(nt_mem_req),
    .mem_addr(nt_mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct { int core; logic [AW-1:0] a; } ack_t;
  typedef struct { int core; logic [DW-1:0] d; logic e; } rv_t;

  ack_t ack_q[$];
  rv_t  rv_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NC-1:0] oh(input int c);
    logic [NC-1:0] one;
    one = 1;
    return one << c;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_addr(input int c, input logic [AW-1:0] a);
    addr[c*AW +: AW] = a;
  endtask

  task automatic expect_fetch(input int c, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic e);
    ack_t x;
    rv_t  y;
    x.core = c; x.a = a;
    y.core = c; y.d = d; y.e = e;
    ack_q.push_back(x);
    rv_q.push_back(y);
  endtask

  // Memory model: wait for mem_req, optionally stall the grant, then return
  // data rv_delay cycles after the first WAIT cycle.
  task automatic serve(input logic [AW-1:0] exp_addr, input int gnt_delay,
                       input int rv_delay, input logic [DW-1:0] d);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    check("mem_req_seen", 64'(mem_req), 64'd1);
    for (int i = 0; i < gnt_delay; i++) begin
      check("stall_mem_req", 64'(mem_req), 64'd1);
      check("stall_mem_addr", 64'(mem_addr), 64'(exp_addr));
      check("stall_no_ack", 64'(ack), 64'd0);
      tick(1);
    end
    mem_gnt = 1'b1;
    tick(1);
    mem_gnt = 1'b0;
    repeat (rv_delay) tick(1);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    tick(1);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (ack != '0) begin
        if (ack_q.size() == 0) begin
          check("unexpected_ack", 64'(ack), 64'd0);
        end else begin
          ack_t x;
          x = ack_q.pop_front();
          check("ack_onehot", 64'(ack), 64'(oh(x.core)));
          check("ack_mem_addr", 64'(mem_addr), 64'(x.a));
          check("ack_owner", 64'(owner), 64'(x.core));
        end
      end
      if (rvalid != '0) begin
        if (rv_q.size() == 0) begin
          check("unexpected_rvalid", 64'(rvalid), 64'd0);
        end else begin
          rv_t y;
          y = rv_q.pop_front();
          check("rvalid_onehot", 64'(rvalid), 64'(oh(y.core)));
          check("rvalid_rdata", 64'(rdata), 64'(y.d));
          check("rvalid_err", 64'(err), 64'(y.e));
          check("rvalid_busy_low", 64'(busy), 64'd0);
        end
      end
      if (err && rvalid == '0) check("err_without_rvalid", 64'(err), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    tick(2);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    reset_n = 1'b1;
    tick(1);

    // ---------------- single requester ----------------
    req = 4'b0001;
    set_addr(0, 32'h100);
    expect_fetch(0, 32'h100, 32'hDEADBEEF, 1'b0);
    serve(32'h100, 0, 0, 32'hDEADBEEF);
    check("single_busy_drop", 64'(busy), 64'd0);
    check("single_rdata", 64'(rdata), 64'hDEADBEEF);
    req = 4'b0000;
    tick(1);
    check("single_rdata_hold", 64'(rdata), 64'hDEADBEEF);

    // ---------------- fairness (priority now at core 1) ----------------
    for (int i = 0; i < NC; i++) set_addr(i, 32'h1000 + 32'(i * 4));
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      int c;
      c = (k + 1) % NC;
      expect_fetch(c, 32'h1000 + 32'(c * 4), 32'hA000_0000 + 32'(k), 1'b0);
      serve(32'h1000 + 32'(c * 4), 0, 0, 32'hA000_0000 + 32'(k));
    end
    req = 4'b0000;
    tick(1);

    // ---------------- grant stall; input changes while busy ignored ----------------
    req = 4'b0100;
    set_addr(2, 32'h2222_0000);
    expect_fetch(2, 32'h2222_0000, 32'h3333_4444, 1'b0);
    tick(1);
    req = 4'b0000;
    set_addr(2, 32'h0000_BAD0);
    serve(32'h2222_0000, 5, 0, 32'h3333_4444);
    tick(1);

    // ---------------- timeout (priority at core 3, wraps to core 0) ----------------
    req = 4'b0001;
    set_addr(0, 32'h300);
    expect_fetch(0, 32'h300, 32'h0, 1'b1);
    tick(1);
    mem_gnt = 1'b1;
    tick(1);
    mem_gnt = 1'b0;
    tick(3);
    check("to_not_yet", 64'(rvalid), 64'd0);
    tick(1);
    check("to_rvalid", 64'(rvalid), 64'b0001);
    check("to_err", 64'(err), 64'd1);
    check("to_rdata_zero", 64'(rdata), 64'd0);
    check("to_busy", 64'(busy), 64'd0);
    req = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      check("nt_still_busy", 64'(nt_busy), 64'd1);
      check("nt_no_rvalid", 64'(nt_rvalid), 64'd0);
      tick(1);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    tick(1);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    check("nt_rvalid", 64'(nt_rvalid), 64'b0001);
    check("nt_rdata", 64'(nt_rdata), 64'h5555_AAAA);
    check("nt_err", 64'(nt_err), 64'd0);
    check("late_rvalid_ignored", 64'(rvalid), 64'd0);
    check("late_rdata_held", 64'(rdata), 64'd0);
    tick(1);

    // ---------------- reset in WAIT, stale response ----------------
    req = 4'b1000;
    set_addr(3, 32'h4444);
    begin
      ack_t x;
      x.core = 3; x.a = 32'h4444;
      ack_q.push_back(x);
    end
    tick(1);
    mem_gnt = 1'b1;
    tick(1);
    mem_gnt = 1'b0;
    tick(1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_owner", 64'(owner), 64'd0);
    check("mid_rst_mem_req", 64'(mem_req), 64'd0);
    check("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
    check("mid_rst_rvalid", 64'(rvalid), 64'd0);
    req = 4'b0000;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h00BA_DBAD;
    tick(1);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    check("stale_no_rvalid", 64'(rvalid), 64'd0);
    check("stale_not_busy", 64'(busy), 64'd0);
    check("stale_rdata", 64'(rdata), 64'd0);
    // Pointer back at 0: core 0 must beat core 1.
    req = 4'b0011;
    set_addr(0, 32'h500);
    set_addr(1, 32'h504);
    expect_fetch(0, 32'h500, 32'h600D_0000, 1'b0);
    serve(32'h500, 0, 0, 32'h600D_0000);
    req = 4'b0010;
    expect_fetch(1, 32'h504, 32'h600D_0001, 1'b0);
    serve(32'h504, 0, 0, 32'h600D_0001);
    req = 4'b0000;
    tick(1);

    // ---------------- spurious rvalid in ISSUE and with gnt ----------------
    req = 4'b0100;
    set_addr(2, 32'h700);
    expect_fetch(2, 32'h700, 32'hCAFE_F00D, 1'b0);
    tick(1);
    req = 4'b0000;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_1111;
    tick(1);
    mem_gnt   = 1'b1;
    mem_rdata = 32'h2222_2222;
    tick(1);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    check("spur_no_rvalid_a", 64'(rvalid), 64'd0);
    check("spur_still_busy", 64'(busy), 64'd1);
    tick(1);
    check("spur_no_rvalid_b", 64'(rvalid), 64'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    tick(1);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    check("spur_real_rdata", 64'(rdata), 64'hCAFE_F00D);
    tick(3);

    check("ack_queue_drained", 64'(ack_q.size()), 64'd0);
    check("rv_queue_drained", 64'(rv_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
